// File: rtl/clock_gen.sv
// CPU clock source: emits a one-cycle clock-enable (tick) plus an observation square wave,
// in full-rate, programmable-divide, debounced single-step or halt mode.
module clock_gen #(
    parameter int unsigned CNT_WIDTH  = 21,
    parameter int unsigned DEB_CYCLES = 1000000,
    parameter int unsigned DEB_WIDTH  = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           mode,
    input  logic [CNT_WIDTH-1:0] div,
    input  logic                 step_btn,
    output logic                 tick,
    output logic                 clk_div,
    output logic                 btn_db
);

    typedef enum logic [1:0] {
        MODE_FULL = 2'b00,
        MODE_DIV  = 2'b01,
        MODE_STEP = 2'b10,
        MODE_HALT = 2'b11
    } mode_t;

    localparam logic [DEB_WIDTH-1:0] DEB_LAST = DEB_WIDTH'(DEB_CYCLES - 1);

    mode_t                mode_in;
    mode_t                mode_q;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_last;
    logic                 mode_chg;
    logic                 wrap;
    logic                 btn_rise;

    logic                 s0;
    logic                 s1;
    logic                 btn_db_q;
    logic [DEB_WIDTH-1:0] deb_cnt;

    // A div of 0 behaves as 1; the >= compare lets a shrinking div wrap immediately.
    always_comb begin
        mode_in  = mode_t'(mode);
        mode_chg = (mode_in != mode_q);
        cnt_last = (div == '0) ? '0 : div - CNT_WIDTH'(1);
        wrap     = (cnt >= cnt_last);
        btn_rise = btn_db & ~btn_db_q;
    end

    // Button synchroniser and debouncer; runs in every mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0       <= 1'b0;
            s1       <= 1'b0;
            btn_db   <= 1'b0;
            btn_db_q <= 1'b0;
            deb_cnt  <= '0;
        end else begin
            s0       <= step_btn;
            s1       <= s0;
            btn_db_q <= btn_db;
            if (s1 == btn_db) begin
                deb_cnt <= '0;
            end else if (deb_cnt >= DEB_LAST) begin
                btn_db  <= s1;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + DEB_WIDTH'(1);
            end
        end
    end

    // Mode sequencer; a mode change always spends one quiet cycle before the new mode runs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q  <= MODE_FULL;
            cnt     <= '0;
            tick    <= 1'b0;
            clk_div <= 1'b0;
        end else begin
            mode_q <= mode_in;
            if (mode_chg) begin
                cnt     <= '0;
                tick    <= 1'b0;
                clk_div <= 1'b0;
            end else begin
                case (mode_q)
                    MODE_FULL: begin
                        cnt     <= '0;
                        tick    <= 1'b1;
                        clk_div <= ~clk_div;
                    end
                    MODE_DIV: begin
                        if (wrap) begin
                            cnt     <= '0;
                            clk_div <= ~clk_div;
                            tick    <= ~clk_div;
                        end else begin
                            cnt  <= cnt + CNT_WIDTH'(1);
                            tick <= 1'b0;
                        end
                    end
                    MODE_STEP: begin
                        cnt     <= '0;
                        tick    <= btn_rise;
                        clk_div <= btn_rise;
                    end
                    default: begin
                        cnt     <= '0;
                        tick    <= 1'b0;
                        clk_div <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clock_gen.sv
// Bench for clock_gen: directed scenarios plus random mode/div/button traffic,
// compared every cycle against a behavioural model of the clock source.
module tb_clock_gen;

    localparam int unsigned CW  = 8;
    localparam int unsigned DEB = 4;

    logic          clk;
    logic          rst;
    logic [1:0]    mode;
    logic [CW-1:0] div;
    logic          step_btn;
    logic          tick;
    logic          clk_div;
    logic          btn_db;

    int n_checks;
    int n_err;
    int cyc;

    // model state
    int m_mode_prev;
    int m_phase;
    bit m_sq;
    bit m_tk;
    bit m_hist0;
    bit m_hist1;
    bit m_level;
    bit m_level_prev;
    int m_run;

    clock_gen #(.CNT_WIDTH(CW), .DEB_CYCLES(DEB), .DEB_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .mode(mode), .div(div), .step_btn(step_btn),
        .tick(tick), .clk_div(clk_div), .btn_db(btn_db)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs == exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode_prev  = 0;
        m_phase      = 0;
        m_sq         = 0;
        m_tk         = 0;
        m_hist0      = 0;
        m_hist1      = 0;
        m_level      = 0;
        m_level_prev = 0;
        m_run        = 0;
    endtask

    // One board-clock edge of the reference behaviour, given the inputs seen at that edge.
    task automatic model_edge(input int md, input int dv, input bit b);
        int  n;
        bit  rose;
        n    = (dv == 0) ? 1 : dv;
        rose = m_level && !m_level_prev;
        if (md != m_mode_prev) begin
            m_phase = 0; m_sq = 0; m_tk = 0;
        end else if (md == 0) begin
            m_phase = 0; m_tk = 1; m_sq = !m_sq;
        end else if (md == 1) begin
            if (m_phase + 1 >= n) begin
                m_phase = 0; m_sq = !m_sq; m_tk = m_sq;
            end else begin
                m_phase = m_phase + 1; m_tk = 0;
            end
        end else if (md == 2) begin
            m_phase = 0; m_tk = rose; m_sq = rose;
        end else begin
            m_phase = 0; m_tk = 0; m_sq = 0;
        end
        m_mode_prev = md;
        // accepted level follows the synced button after DEB consecutive differing cycles
        m_level_prev = m_level;
        if (m_hist1 == m_level) m_run = 0;
        else if (m_run + 1 >= DEB) begin m_level = m_hist1; m_run = 0; end
        else m_run = m_run + 1;
        m_hist1 = m_hist0;
        m_hist0 = b;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        model_edge(int'(mode), int'(div), step_btn);
        chk("tick", tick, m_tk);
        chk("clk_div", clk_div, m_sq);
        chk("btn_db", btn_db, m_level);
    endtask

    initial begin
        int ticks;
        int first;
        int s;
        int toggles;
        logic prev;
        bit bounce_press[6];
        bit bounce_rel[8];

        n_checks = 0; n_err = 0; cyc = 0;
        rst = 1'b1; mode = 2'b00; div = '0; step_btn = 1'b0;
        model_reset();
        #2;
        chk("rst_tick", tick, 1'b0);
        chk("rst_clk_div", clk_div, 1'b0);
        chk("rst_btn_db", btn_db, 1'b0);
        @(posedge clk); #1; rst = 1'b0;

        // full-rate
        for (int i = 0; i < 8; i++) cycle();

        // asynchronous reset mid-run
        #3; rst = 1'b1; #1;
        chk("async_rst_tick", tick, 1'b0);
        chk("async_rst_clk_div", clk_div, 1'b0);
        chk("async_rst_btn_db", btn_db, 1'b0);
        @(posedge clk); #1; rst = 1'b0; model_reset();
        for (int i = 0; i < 4; i++) cycle();

        // divide by 3: ten ticks in any 60-cycle window once running
        mode = 2'b01; div = CW'(3);
        for (int i = 0; i < 8; i++) cycle();
        ticks = 0;
        for (int i = 0; i < 60; i++) begin cycle(); if (tick) ticks++; end
        chk_int("div3_ticks", ticks, 10);

        // div = 0 behaves as 1
        div = '0;
        for (int i = 0; i < 4; i++) cycle();
        ticks = 0;
        for (int i = 0; i < 20; i++) begin cycle(); if (tick) ticks++; end
        chk_int("div0_ticks", ticks, 10);

        // shrink div from 100 to 10 at cnt = 50
        mode = 2'b11; cycle(); cycle();
        mode = 2'b01; div = CW'(100);
        for (int i = 0; i < 200 && m_phase != 50; i++) cycle();
        chk_int("reach_cnt50", m_phase, 50);
        div = CW'(10);
        prev = clk_div;
        cycle();
        chk("div_shrink_wrap", clk_div, ~prev);
        toggles = 0;
        for (int i = 0; i < 40; i++) begin
            prev = clk_div; cycle();
            if (clk_div !== prev) toggles++;
        end
        chk_int("div10_toggles", toggles, 4);

        // largest divisor for this counter width
        div = CW'(255);
        for (int i = 0; i < 520; i++) cycle();

        // clean press in single-step mode
        mode = 2'b10;
        for (int i = 0; i < 4; i++) cycle();
        step_btn = 1'b1; s = cyc; ticks = 0; first = -1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (tick) begin ticks++; if (first < 0) first = cyc; end
        end
        chk_int("press_ticks", ticks, 1);
        chk_int("press_latency", first - s, 7);
        step_btn = 1'b0; ticks = 0;
        for (int i = 0; i < 15; i++) begin cycle(); if (tick) ticks++; end
        chk_int("release_ticks", ticks, 0);

        // bouncing press, then bouncing release
        bounce_press = '{1, 0, 1, 1, 0, 1};
        bounce_rel   = '{0, 1, 0, 0, 1, 1, 1, 0};
        ticks = 0; first = -1; s = 0;
        for (int i = 0; i < 6; i++) begin
            step_btn = bounce_press[i]; s = cyc;
            cycle();
            if (tick) ticks++;
        end
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (tick) begin ticks++; if (first < 0) first = cyc; end
        end
        chk_int("bounce_ticks", ticks, 1);
        chk_int("bounce_latency", first - s, 7);
        ticks = 0;
        for (int i = 0; i < 8; i++) begin
            step_btn = bounce_rel[i];
            cycle();
            if (tick) ticks++;
        end
        for (int i = 0; i < 15; i++) begin cycle(); if (tick) ticks++; end
        chk_int("bounce_release_ticks", ticks, 0);

        // divide -> halt while clk_div is high, then halt -> divide
        mode = 2'b01; div = CW'(3);
        for (int i = 0; i < 12; i++) cycle();
        for (int i = 0; i < 20 && !m_sq; i++) cycle();
        chk("pre_halt_high", clk_div, 1'b1);
        mode = 2'b11;
        cycle();
        chk("halt_clk_div", clk_div, 1'b0);
        chk("halt_tick", tick, 1'b0);
        for (int i = 0; i < 10; i++) cycle();
        mode = 2'b01; s = cyc; first = -1;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (tick && first < 0) first = cyc;
        end
        chk_int("resume_first_tick", first - s, 4);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) div = CW'($urandom_range(0, 6));
            if ($urandom_range(0, 11) == 0) step_btn = ~step_btn;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
